mips_mem_arbiter: RTL and testbench

Avalon memory-mapped master sitting between the CPU's instruction-fetch and data-access ports and the single shared Avalon memory slave. Arbitrates between the two requesters and latches the winning request into a bus transaction. Holds address, writedata and byteenable constant while waitrequest is high, then returns readdata with a one-cycle acknowledge. Rejects misaligned data accesses locally and flags stalled transactions with a watchdog.

---
 rtl/mips_mem_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_mips_mem_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_mem_arbiter.sv
// Avalon-MM master arbitrating the CPU fetch and data ports onto one shared slave.
// Round-robin between the two ports. Misaligned data accesses are answered locally.
// A sticky watchdog flags long waitrequest stalls but does not abort the transfer.
module mips_mem_arbiter #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ack,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [3:0]  d_be,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic        d_err,
    output logic [31:0] d_rdata,
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic        waitrequest,
    input  logic [31:0] readdata,
    output logic        bus_timeout
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {StIdle, StBus, StResp} state_e;

    state_e          state_q, state_d;
    logic            gnt_data_q, gnt_data_d;   // current transaction belongs to the data port
    logic            last_data_q, last_data_d; // last grant went to the data port
    logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
    logic            bus_timeout_q, bus_timeout_d;
    logic [31:0]     address_q, address_d;
    logic            read_q, read_d;
    logic            write_q, write_d;
    logic [31:0]     writedata_q, writedata_d;
    logic [3:0]      byteenable_q, byteenable_d;
    logic            i_ack_q, i_ack_d;
    logic [31:0]     i_rdata_q, i_rdata_d;
    logic            d_ack_q, d_ack_d;
    logic            d_err_q, d_err_d;
    logic [31:0]     d_rdata_q, d_rdata_d;
    logic            pick_data;

    // Next-state: arbitration, bus issue/hold, completion and watchdog.
    always_comb begin
        state_d       = state_q;
        gnt_data_d    = gnt_data_q;
        last_data_d   = last_data_q;
        wait_cnt_d    = wait_cnt_q;
        address_d     = address_q;
        read_d        = read_q;
        write_d       = write_q;
        writedata_d   = writedata_q;
        byteenable_d  = byteenable_q;
        i_ack_d       = 1'b0;
        i_rdata_d     = i_rdata_q;
        d_ack_d       = 1'b0;
        d_err_d       = 1'b0;
        d_rdata_d     = d_rdata_q;
        // On a tie the data port wins unless it was the one granted last.
        pick_data     = d_req && (!i_req || !last_data_q);

        case (state_q)
            StIdle: begin
                if (d_req || i_req) begin
                    gnt_data_d  = pick_data;
                    last_data_d = pick_data;
                    if (pick_data && (d_addr[1:0] != 2'b00)) begin
                        state_d   = StResp;
                        d_ack_d   = 1'b1;
                        d_err_d   = 1'b1;
                        d_rdata_d = '0;
                    end else begin
                        state_d    = StBus;
                        wait_cnt_d = '0;
                        if (pick_data) begin
                            address_d    = {d_addr[31:2], 2'b00};
                            read_d       = !d_we;
                            write_d      = d_we;
                            byteenable_d = d_be;
                            writedata_d  = d_wdata;
                        end else begin
                            address_d    = {i_addr[31:2], 2'b00};
                            read_d       = 1'b1;
                            write_d      = 1'b0;
                            byteenable_d = 4'b1111;
                        end
                    end
                end
            end
            StBus: begin
                if (waitrequest) begin
                    // Saturate so the count never wraps during a very long stall.
                    if (wait_cnt_q < CntW'(TIMEOUT)) begin
                        wait_cnt_d = wait_cnt_q + CntW'(1);
                    end
                end else begin
                    state_d = StResp;
                    read_d  = 1'b0;
                    write_d = 1'b0;
                    if (gnt_data_q) begin
                        d_ack_d = 1'b1;
                        if (read_q) begin
                            d_rdata_d = readdata;
                        end
                    end else begin
                        i_ack_d = 1'b1;
                        if (read_q) begin
                            i_rdata_d = readdata;
                        end
                    end
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        bus_timeout_d = bus_timeout_q || ((state_q == StBus) && (wait_cnt_d == CntW'(TIMEOUT)));
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            gnt_data_q    <= 1'b0;
            last_data_q   <= 1'b0;
            wait_cnt_q    <= '0;
            bus_timeout_q <= 1'b0;
            address_q     <= '0;
            read_q        <= 1'b0;
            write_q       <= 1'b0;
            writedata_q   <= '0;
            byteenable_q  <= '0;
            i_ack_q       <= 1'b0;
            i_rdata_q     <= '0;
            d_ack_q       <= 1'b0;
            d_err_q       <= 1'b0;
            d_rdata_q     <= '0;
        end else begin
            state_q       <= state_d;
            gnt_data_q    <= gnt_data_d;
            last_data_q   <= last_data_d;
            wait_cnt_q    <= wait_cnt_d;
            bus_timeout_q <= bus_timeout_d;
            address_q     <= address_d;
            read_q        <= read_d;
            write_q       <= write_d;
            writedata_q   <= writedata_d;
            byteenable_q  <= byteenable_d;
            i_ack_q       <= i_ack_d;
            i_rdata_q     <= i_rdata_d;
            d_ack_q       <= d_ack_d;
            d_err_q       <= d_err_d;
            d_rdata_q     <= d_rdata_d;
        end
    end

    assign address     = address_q;
    assign read        = read_q;
    assign write       = write_q;
    assign writedata   = writedata_q;
    assign byteenable  = byteenable_q;
    assign i_ack       = i_ack_q;
    assign i_rdata     = i_rdata_q;
    assign d_ack       = d_ack_q;
    assign d_err       = d_err_q;
    assign d_rdata     = d_rdata_q;
    assign bus_timeout = bus_timeout_q;

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Directed bench for mips_mem_arbiter with a small Avalon slave model.
module tb_mips_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [3:0]  d_be = '0;
    logic [31:0] d_wdata = '0;
    logic        d_ack;
    logic        d_err;
    logic [31:0] d_rdata;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic        waitrequest;
    logic [31:0] readdata;
    logic        bus_timeout;

    // Slave model state
    int          slv_delay = 0;
    logic        hold_wait = 1'b0;
    int          slv_cnt;
    logic [31:0] mem [0:15];
    logic        rw_both;

    int n_pass = 0;
    int n_total = 0;

    mips_mem_arbiter #(.TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_be(d_be), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_err(d_err), .d_rdata(d_rdata),
        .address(address), .read(read), .write(write), .writedata(writedata),
        .byteenable(byteenable), .waitrequest(waitrequest), .readdata(readdata),
        .bus_timeout(bus_timeout)
    );

    always #5 clk = ~clk;

    assign waitrequest = (read || write) && (hold_wait || (slv_cnt < slv_delay));
    assign readdata    = mem[address[5:2]];

    // Slave: counts wait cycles, commits byte-enabled writes on the final cycle.
    always @(posedge clk) begin
        if (!rst_n) begin
            slv_cnt <= 0;
            rw_both <= 1'b0;
            mem[1]  <= 32'h2402000A;
            mem[4]  <= 32'h12345678;
        end else begin
            if (read && write) rw_both <= 1'b1;
            if (read || write) begin
                if (waitrequest) begin
                    slv_cnt <= slv_cnt + 1;
                end else begin
                    slv_cnt <= 0;
                    if (write) begin
                        for (int b = 0; b < 4; b++) begin
                            if (byteenable[b]) mem[address[5:2]][8*b +: 8] <= writedata[8*b +: 8];
                        end
                    end
                end
            end else begin
                slv_cnt <= 0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for the selected ack, bounded; expiry counts as a failed check.
    task automatic wait_ack(input bit is_data, input int budget, input string tag);
        int n = 0;
        while (!(is_data ? d_ack : i_ack) && n < budget) begin
            tick();
            n++;
        end
        check(tag, 32'(is_data ? d_ack : i_ack), 32'd1);
    endtask

    initial begin
        // Reset
        repeat (3) @(posedge clk);
        #1;
        check("rst_read", 32'(read), 32'd0);
        check("rst_write", 32'(write), 32'd0);
        check("rst_addr", address, 32'd0);
        rst_n = 1'b1;
        tick();

        // Fetch, delay 2
        slv_delay = 2;
        i_addr = 32'hBFC00004;
        i_req = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("fetch_read_c%0d", c), 32'(read), 32'd1);
            check($sformatf("fetch_addr_c%0d", c), address, 32'hBFC00004);
            check($sformatf("fetch_be_c%0d", c), 32'(byteenable), 32'hF);
        end
        tick();
        check("fetch_read_drop", 32'(read), 32'd0);
        check("fetch_iack", 32'(i_ack), 32'd1);
        check("fetch_dack", 32'(d_ack), 32'd0);
        check("fetch_rdata", i_rdata, 32'h2402000A);
        i_req = 1'b0;
        tick();
        check("fetch_iack_pulse", 32'(i_ack), 32'd0);

        // Tie held: grants alternate D, I, D, I
        slv_delay = 1;
        d_addr = 32'h10;
        d_we = 1'b0;
        i_req = 1'b1;
        d_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            int n = 0;
            while (!(i_ack || d_ack) && n < 20) begin
                tick();
                n++;
            end
            check($sformatf("tie%0d_dack", k), 32'(d_ack), 32'((k % 2) == 0));
            check($sformatf("tie%0d_iack", k), 32'(i_ack), 32'((k % 2) == 1));
            tick();
        end
        i_req = 1'b0;
        d_req = 1'b0;
        tick();
        check("tie_no_rw_both", 32'(rw_both), 32'd0);

        // Data write, delay 3
        slv_delay = 3;
        d_addr = 32'h10;
        d_we = 1'b1;
        d_be = 4'b0011;
        d_wdata = 32'hDEADBEEF;
        d_req = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            check($sformatf("wr_write_c%0d", c), 32'(write), 32'd1);
            check($sformatf("wr_addr_c%0d", c), address, 32'h10);
            check($sformatf("wr_wdata_c%0d", c), writedata, 32'hDEADBEEF);
            check($sformatf("wr_be_c%0d", c), 32'(byteenable), 32'h3);
        end
        tick();
        check("wr_write_drop", 32'(write), 32'd0);
        check("wr_dack", 32'(d_ack), 32'd1);
        check("wr_derr", 32'(d_err), 32'd0);
        d_req = 1'b0;
        tick();

        // Read back merged word, delay 0
        slv_delay = 0;
        d_we = 1'b0;
        d_req = 1'b1;
        wait_ack(1'b1, 10, "rd_dack");
        check("rd_rdata", d_rdata, 32'h1234BEEF);
        d_req = 1'b0;
        tick();

        // Watchdog: waitrequest forced high for 20 cycles
        slv_delay = 2;
        hold_wait = 1'b1;
        i_addr = 32'h4;
        i_req = 1'b1;
        tick();
        for (int c = 0; c < 7; c++) tick();
        check("wd_before", 32'(bus_timeout), 32'd0);
        tick();
        check("wd_set", 32'(bus_timeout), 32'd1);
        for (int c = 0; c < 12; c++) tick();
        check("wd_still_read", 32'(read), 32'd1);
        hold_wait = 1'b0;
        wait_ack(1'b0, 10, "wd_iack");
        check("wd_rdata", i_rdata, 32'h2402000A);
        check("wd_sticky", 32'(bus_timeout), 32'd1);
        i_req = 1'b0;
        tick();

        // Misaligned data read
        d_addr = 32'h13;
        d_we = 1'b0;
        d_req = 1'b1;
        tick();
        check("mis_dack", 32'(d_ack), 32'd1);
        check("mis_derr", 32'(d_err), 32'd1);
        check("mis_rdata", d_rdata, 32'd0);
        check("mis_read", 32'(read), 32'd0);
        check("mis_write", 32'(write), 32'd0);
        d_req = 1'b0;
        tick();
        check("mis_dack_pulse", 32'(d_ack), 32'd0);
        check("mis_bus_idle", 32'(read || write), 32'd0);

        // Asynchronous reset in IDLE (last grant was data)
        rst_n = 1'b0;
        #1;
        check("ar_addr", address, 32'd0);
        check("ar_be", 32'(byteenable), 32'd0);
        check("ar_wdata", writedata, 32'd0);
        check("ar_irdata", i_rdata, 32'd0);
        check("ar_timeout", 32'(bus_timeout), 32'd0);
        check("ar_acks", 32'({i_ack, d_ack, d_err, read, write}), 32'd0);
        check("ar_drdata", d_rdata, 32'd0);
        #2;
        rst_n = 1'b1;
        tick();

        // First tie after reset goes to data
        slv_delay = 0;
        d_addr = 32'h10;
        i_addr = 32'h4;
        d_req = 1'b1;
        i_req = 1'b1;
        begin
            int n = 0;
            while (!(i_ack || d_ack) && n < 20) begin
                tick();
                n++;
            end
        end
        check("post_rst_tie_dack", 32'(d_ack), 32'd1);
        check("post_rst_tie_iack", 32'(i_ack), 32'd0);
        d_req = 1'b0;
        i_req = 1'b0;
        repeat (3) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
